// File: rtl/keypad_scanner.sv
// 4x3 active-low matrix keypad scanner: one column driven at a time, single-key
// press/release debounce, and one-cycle strobes for digits, '*' (clearn) and '#' (startn).
module keypad_scanner #(
  parameter int SCAN_DIV   = 1000,
  parameter int DEBOUNCE_N = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row_n,
  output logic [2:0] col_n,
  output logic [0:9] switches,
  output logic       clearn,
  output logic       startn,
  output logic       key_valid,
  output logic [3:0] key_code
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CNT_W = $clog2(DEBOUNCE_N + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEBOUNCE_N);

  typedef enum logic [1:0] {SCAN, DEBOUNCE, EMIT, WAIT_RELEASE} state_t;

  state_t           r_state, w_state_nxt;
  logic [DIV_W-1:0] r_div;
  logic [1:0]       r_col, w_col_nxt;
  logic [1:0]       r_row, w_row_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [2:0]       r_col_n;
  logic [0:9]       r_switches, w_sw_nxt;
  logic             r_clearn, r_startn, r_key_valid;
  logic [3:0]       r_key_code, w_code;
  logic             w_sample, w_any_low, w_cap_low, w_emit;
  logic [1:0]       w_low_row;

  function automatic logic [1:0] f_next_col(input logic [1:0] c);
    return (c == 2'd2) ? 2'd0 : c + 2'd1;
  endfunction

  function automatic logic [3:0] f_key_code(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] code;
    if (row == 2'd3) begin
      case (col)
        2'd0:    code = 4'd10;
        2'd2:    code = 4'd11;
        default: code = 4'd0;
      endcase
    end else begin
      code = 4'(row) * 4'd3 + 4'(col) + 4'd1;
    end
    return code;
  endfunction

  assign w_sample  = (r_div == DIV_LAST);
  assign w_any_low = ~&row_n;
  assign w_cap_low = ~row_n[r_row];

  // Lowest-index low row wins when several rows in the driven column are pressed.
  always_comb begin
    w_low_row = 2'd0;
    if (!row_n[0])      w_low_row = 2'd0;
    else if (!row_n[1]) w_low_row = 2'd1;
    else if (!row_n[2]) w_low_row = 2'd2;
    else if (!row_n[3]) w_low_row = 2'd3;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_col_nxt   = r_col;
    w_row_nxt   = r_row;
    w_cnt_nxt   = r_cnt;
    unique case (r_state)
      SCAN: begin
        if (w_sample) begin
          if (w_any_low) begin
            w_row_nxt   = w_low_row;
            w_cnt_nxt   = CNT_W'(1);
            w_state_nxt = (DEBOUNCE_N == 1) ? EMIT : DEBOUNCE;
          end else begin
            w_col_nxt = f_next_col(r_col);
          end
        end
      end
      DEBOUNCE: begin
        if (w_sample) begin
          if (w_cap_low) begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
            if (w_cnt_nxt == CNT_DONE) w_state_nxt = EMIT;
          end else begin
            w_state_nxt = SCAN;
            w_col_nxt   = f_next_col(r_col);
          end
        end
      end
      EMIT: begin
        w_cnt_nxt   = '0;
        w_state_nxt = WAIT_RELEASE;
      end
      WAIT_RELEASE: begin
        if (w_sample) begin
          w_cnt_nxt = w_cap_low ? '0 : r_cnt + CNT_W'(1);
          if (w_cnt_nxt == CNT_DONE) begin
            w_state_nxt = SCAN;
            w_col_nxt   = f_next_col(r_col);
          end
        end
      end
    endcase
  end

  // Strobes are registered on the edge that enters EMIT, so they coincide with that state.
  assign w_emit = (w_state_nxt == EMIT);
  assign w_code = f_key_code(w_row_nxt, r_col);

  always_comb begin
    w_sw_nxt = '0;
    for (int d = 0; d < 10; d++) w_sw_nxt[d] = w_emit && (w_code == 4'(d));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= SCAN;
      r_div       <= '0;
      r_col       <= 2'd0;
      r_row       <= 2'd0;
      r_cnt       <= '0;
      r_col_n     <= 3'b110;
      r_switches  <= '0;
      r_clearn    <= 1'b1;
      r_startn    <= 1'b1;
      r_key_valid <= 1'b0;
      r_key_code  <= 4'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_div       <= w_sample ? '0 : r_div + DIV_W'(1);
      r_col       <= w_col_nxt;
      r_row       <= w_row_nxt;
      r_cnt       <= w_cnt_nxt;
      r_col_n     <= ~(3'b001 << w_col_nxt);
      r_switches  <= w_sw_nxt;
      r_clearn    <= ~(w_emit && (w_code == 4'd10));
      r_startn    <= ~(w_emit && (w_code == 4'd11));
      r_key_valid <= w_emit;
      if (w_emit) r_key_code <= w_code;
    end
  end

  assign col_n     = r_col_n;
  assign switches  = r_switches;
  assign clearn    = r_clearn;
  assign startn    = r_startn;
  assign key_valid = r_key_valid;
  assign key_code  = r_key_code;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a physical keypad model drives row_n, a scoreboard queue holds
// expected strobes (code and cycle) and a monitor pops and compares whenever a strobe appears.
module tb_keypad_scanner;

  localparam int SD = 4;
  localparam int N  = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] row_n;
  logic [2:0] col_n;
  logic [0:9] switches;
  logic       clearn, startn, key_valid;
  logic [3:0] key_code;

  keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_N(N)) dut (
    .clk(clk), .rst(rst), .row_n(row_n), .col_n(col_n), .switches(switches),
    .clearn(clearn), .startn(startn), .key_valid(key_valid), .key_code(key_code)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;
  int last_code = 0;

  typedef struct {int code; int at;} exp_t;
  exp_t exp_q[$];

  bit pressed [4][3];

  // Keypad: a row reads low when a pressed key sits on it in the driven column.
  always_comb begin
    row_n = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 3; c++)
        if (pressed[r][c] && !col_n[c]) row_n[r] = 1'b0;
  end

  function automatic int krow(input int k);
    if (k >= 1 && k <= 9) return (k - 1) / 3;
    return 3;
  endfunction

  function automatic int kcol(input int k);
    if (k >= 1 && k <= 9) return (k - 1) % 3;
    if (k == 10) return 0;
    if (k == 11) return 2;
    return 1;
  endfunction

  function automatic int colpat(input int c);
    logic [2:0] p;
    p = 3'b111;
    p[c] = 1'b0;
    return int'(p);
  endfunction

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, exp, cyc);
  endtask

  task automatic release_all();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 3; c++) pressed[r][c] = 1'b0;
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  // Returns at the negedge of the first cycle in which column c is driven.
  task automatic wait_col_start(input int c);
    int prev;
    int budget;
    prev = int'(col_n);
    budget = 0;
    forever begin
      @(negedge clk);
      if (int'(col_n) == colpat(c) && prev != colpat(c)) break;
      prev = int'(col_n);
      budget++;
      if (budget > 60) begin
        check("col_wait_timeout", int'(col_n), colpat(c));
        break;
      end
    end
  endtask

  // Hold key k across h of its column's sample points, release, and check the scan resumes.
  task automatic do_press(input int k, input int h);
    int c, s0, rlast, adv;
    c = kcol(k);
    wait_col_start(c);
    s0 = cyc + SD - 1;
    pressed[krow(k)][c] = 1'b1;
    if (h >= N) begin
      exp_q.push_back('{code: k, at: s0 + (N - 1) * SD + 1});
      last_code = k;
    end
    rlast = s0 + (h - 1) * SD;
    wait_until(rlast + 1);
    release_all();
    adv = (h >= N) ? rlast + N * SD + 1 : rlast + SD + 1;
    wait_until(adv - 1);
    check("col_frozen", int'(col_n), colpat(c));
    @(negedge clk);
    check("col_resume", int'(col_n), colpat((c + 1) % 3));
    check("code_hold", int'(key_code), last_code);
  endtask

  always @(negedge clk) begin
    if (key_valid || switches != '0 || !clearn || !startn) begin
      if (exp_q.size() == 0) begin
        check("unexpected_strobe_code", int'(key_code), -1);
      end else begin
        exp_t e;
        logic [0:9] esw;
        e = exp_q.pop_front();
        esw = '0;
        if (e.code < 10) esw[e.code] = 1'b1;
        check("strobe_cycle", cyc, e.at);
        check("key_valid", int'(key_valid), 1);
        check("key_code", int'(key_code), e.code);
        check("switches", int'(switches), int'(esw));
        check("clearn", int'(clearn), (e.code == 10) ? 0 : 1);
        check("startn", int'(startn), (e.code == 11) ? 0 : 1);
      end
    end else if (exp_q.size() > 0 && exp_q[0].at < cyc) begin
      check("strobe_missing_at", cyc, exp_q[0].at);
      void'(exp_q.pop_front());
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int s0, rlast, s8, c;
    release_all();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Reset values, then an idle rotation of the column drive.
    check("rst_switches", int'(switches), 0);
    check("rst_clearn", int'(clearn), 1);
    check("rst_startn", int'(startn), 1);
    check("rst_key_valid", int'(key_valid), 0);
    check("rst_key_code", int'(key_code), 0);
    for (int i = 0; i <= 12; i++) begin
      check("idle_col", int'(col_n), colpat((i / SD) % 3));
      if (i < 12) @(negedge clk);
    end

    do_press(5, 6);
    do_press(5, 2);
    do_press(10, 4);
    do_press(11, 5);

    // '2' and '8' together in column 1, then '2' released while '8' stays down.
    wait_col_start(1);
    s0 = cyc + SD - 1;
    pressed[0][1] = 1'b1;
    pressed[2][1] = 1'b1;
    exp_q.push_back('{code: 2, at: s0 + (N - 1) * SD + 1});
    rlast = s0 + 4 * SD;
    wait_until(rlast + 1);
    pressed[0][1] = 1'b0;
    s8 = rlast + (N + 3) * SD;
    exp_q.push_back('{code: 8, at: s8 + (N - 1) * SD + 1});
    wait_until(s8 + (N - 1) * SD + 1);
    release_all();
    last_code = 8;
    wait_until(s8 + (N - 1) * SD + N * SD + 1);
    check("multi_col_resume", int'(col_n), colpat(2));
    check("multi_code_hold", int'(key_code), 8);

    // Reset while debouncing '5' after two matching samples.
    wait_col_start(1);
    s0 = cyc + SD - 1;
    pressed[1][1] = 1'b1;
    wait_until(s0 + SD + 1);
    rst = 1'b1;
    @(negedge clk);
    check("abort_col_n", int'(col_n), colpat(0));
    check("abort_key_code", int'(key_code), 0);
    check("abort_key_valid", int'(key_valid), 0);
    check("abort_switches", int'(switches), 0);
    check("abort_clearn", int'(clearn), 1);
    check("abort_startn", int'(startn), 1);
    release_all();
    rst = 1'b0;
    last_code = 0;
    repeat (3 * N * SD) @(negedge clk);

    for (int i = 0; i < 14; i++) begin
      int k, h;
      k = int'($urandom_range(0, 11));
      h = int'($urandom_range(1, N + 3));
      c = kcol(k);
      do_press(k, h);
    end

    repeat (4 * SD) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
